digit_scan: RTL and testbench



---
 rtl/digit_pkg.sv | 27 ++
 rtl/scan_prescaler.sv | 38 +++
 rtl/digit_scan.sv | 115 +++++++++++
 tb/tb_digit_scan.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/digit_pkg.sv
// Shared constants and slot helpers for the multiplexed seven-segment scanner.
package digit_pkg;

  localparam logic [7:0] SEG_BLANK   = 8'hFF;
  localparam logic [7:0] SEG_ZERO    = 8'h81;
  localparam logic [7:0] SEG_MARK_LO = 8'h01;
  localparam logic [7:0] SEG_MARK_HI = 8'hFE;
  localparam logic [3:0] AN_OFF      = 4'hF;

  typedef logic [1:0] slot_idx_t;

  localparam slot_idx_t SLOT_D1 = 2'd0;
  localparam slot_idx_t SLOT_D2 = 2'd1;
  localparam slot_idx_t SLOT_D3 = 2'd2;
  localparam slot_idx_t SLOT_D4 = 2'd3;

  // Active-low enable for a slot: slot 0 drives the leftmost digit on an[3].
  function automatic logic [3:0] an_for_slot(slot_idx_t idx);
    case (idx)
      SLOT_D1: return 4'b0111;
      SLOT_D2: return 4'b1011;
      SLOT_D3: return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot timebase for digit_scan: cycle counter within a slot plus the 2-bit slot index.
module scan_prescaler
  import digit_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int DEAD     = 16
) (
  input  logic      clk,
  input  logic      rst,
  output slot_idx_t idx,
  output logic      slot_end,
  output logic      frame_end,
  output logic      in_dead
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD);

  logic [CNT_W-1:0] cnt;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == SLOT_D4);
  assign in_dead   = (cnt < CNT_DEAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= SLOT_D1;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/digit_scan.sv
// Four-digit multiplexed seven-segment scanner with per-frame snapshot and dead-time blanking.
// Define CURSOR_BLINK_EN to blink the rightmost digit every BLINK_DIV frames.
module digit_scan
  import digit_pkg::*;
#(
  parameter int PRESCALE  = 50000,
  parameter int DEAD      = 16,
  parameter int BLINK_DIV = 8
) (
  input  logic       clknew,
  input  logic       rst,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  input  logic [7:0] d3,
  input  logic [7:0] d4,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       frame
);

  slot_idx_t  idx_p0;
  logic       slot_end_p0;
  logic       frame_end_p0;
  logic       in_dead_p0;
  logic [7:0] s1, s2, s3, s4;
  logic       primed;
  logic       cursor_hide;
  logic [7:0] seg_p0;
  logic [3:0] an_p0;

  scan_prescaler #(
    .PRESCALE(PRESCALE),
    .DEAD    (DEAD)
  ) u_prescaler (
    .clk      (clknew),
    .rst      (rst),
    .idx      (idx_p0),
    .slot_end (slot_end_p0),
    .frame_end(frame_end_p0),
    .in_dead  (in_dead_p0)
  );

  // Snapshot: codes are frozen on the last cycle of the last slot so a frame never tears.
  // primed keeps the digit enables off until the first real snapshot exists.
  always_ff @(posedge clknew or posedge rst) begin
    if (rst) begin
      s1     <= SEG_BLANK;
      s2     <= SEG_BLANK;
      s3     <= SEG_BLANK;
      s4     <= SEG_BLANK;
      primed <= 1'b0;
    end else if (slot_end_p0 && (idx_p0 == SLOT_D4)) begin
      s1     <= d1;
      s2     <= d2;
      s3     <= d3;
      s4     <= d4;
      primed <= 1'b1;
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;

  always_ff @(posedge clknew or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_end_p0) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign cursor_hide = ~blink_on;
`else
  // BLINK_DIV is always positive, so the cursor is never hidden without blink logic.
  assign cursor_hide = (BLINK_DIV < 0);
`endif

  always_comb begin
    seg_p0 = SEG_BLANK;
    an_p0  = AN_OFF;
    if (primed && !in_dead_p0) begin
      an_p0 = an_for_slot(idx_p0);
      case (idx_p0)
        SLOT_D1: seg_p0 = s1;
        SLOT_D2: seg_p0 = s2;
        SLOT_D3: seg_p0 = s3;
        default: seg_p0 = cursor_hide ? SEG_BLANK : s4;
      endcase
    end
  end

  // Output stage: one cycle behind the slot state.
  always_ff @(posedge clknew or posedge rst) begin
    if (rst) begin
      seg   <= SEG_BLANK;
      an    <= AN_OFF;
      frame <= 1'b0;
    end else begin
      seg   <= seg_p0;
      an    <= an_p0;
      frame <= frame_end_p0;
    end
  end

endmodule

// File: tb/tb_digit_scan.sv
// Directed bench for digit_scan with PRESCALE=8, DEAD=2, BLINK_DIV=2 (32-cycle frames).
module tb_digit_scan;

  localparam int PRESCALE  = 8;
  localparam int DEAD      = 2;
  localparam int BLINK_DIV = 2;
  localparam int FRAME_LEN = 4 * PRESCALE;
`ifdef CURSOR_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic       clknew = 1'b0;
  logic       rst    = 1'b0;
  logic [7:0] d1, d2, d3, d4;
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame;

  int total = 0;
  int bad   = 0;
  int ec    = 0;

  digit_scan #(
    .PRESCALE (PRESCALE),
    .DEAD     (DEAD),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clknew(clknew),
    .rst   (rst),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .d4    (d4),
    .seg   (seg),
    .an    (an),
    .frame (frame)
  );

  always #5 clknew = ~clknew;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

  // Expected enables for position p of frame f (frame 0 after reset is dark).
  function automatic logic [3:0] exp_an(int p, int f);
    if (f == 0 || (p % PRESCALE) < DEAD) return 4'hF;
    case (p / PRESCALE)
      0:       return 4'b0111;
      1:       return 4'b1011;
      2:       return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  // codes = {d1,d2,d3,d4} as captured for frame f.
  function automatic logic [7:0] exp_seg(int p, int f, logic [31:0] codes);
    if (f == 0 || (p % PRESCALE) < DEAD) return 8'hFF;
    case (p / PRESCALE)
      0:       return codes[31:24];
      1:       return codes[23:16];
      2:       return codes[15:8];
      default: begin
        if (BLINK_EN && ((f / BLINK_DIV) % 2) == 1) return 8'hFF;
        return codes[7:0];
      end
    endcase
  endfunction

  task automatic step(output int p, output int f);
    @(posedge clknew);
    #1;
    p  = ec % FRAME_LEN;
    f  = ec / FRAME_LEN;
    ec = ec + 1;
  endtask

  task automatic do_reset();
    @(negedge clknew);
    rst = 1'b1;
    @(negedge clknew);
    rst = 1'b0;
    ec  = 0;
  endtask

  task automatic test_reset();
    int p, f;
    #2 rst = 1'b1;
    #1;
    total++; if (seg !== 8'hFF) begin bad++; $display("FAIL reset_seg: got %h want ff", seg); end
    total++; if (an !== 4'hF) begin bad++; $display("FAIL reset_an: got %h want f", an); end
    total++; if (frame !== 1'b0) begin bad++; $display("FAIL reset_frame: got %b want 0", frame); end
    @(negedge clknew);
    rst = 1'b0;
    ec  = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      step(p, f);
      total++; if (an !== 4'hF) begin bad++; $display("FAIL blank_an p%0d: got %h want f", p, an); end
      total++; if (seg !== 8'hFF) begin bad++; $display("FAIL blank_seg p%0d: got %h want ff", p, seg); end
      total++; if (frame !== (p == FRAME_LEN - 1)) begin
        bad++; $display("FAIL blank_frame p%0d: got %b want %b", p, frame, (p == FRAME_LEN - 1));
      end
    end
  endtask

  task automatic test_display();
    int p, f;
    logic [31:0] codes = {8'h81, 8'hCF, 8'h92, 8'h86};
    for (int i = 0; i < FRAME_LEN; i++) begin
      step(p, f);
      total++; if (an !== exp_an(p, f)) begin bad++; $display("FAIL disp_an f%0d p%0d: got %h want %h", f, p, an, exp_an(p, f)); end
      total++; if (seg !== exp_seg(p, f, codes)) begin bad++; $display("FAIL disp_seg f%0d p%0d: got %h want %h", f, p, seg, exp_seg(p, f, codes)); end
      total++; if (frame !== (p == FRAME_LEN - 1)) begin bad++; $display("FAIL disp_frame f%0d p%0d: got %b", f, p, frame); end
    end
  endtask

  // d2 changes mid-slot-1; d3 changes on the frame cycle and d1 the cycle after it.
  task automatic test_snapshot();
    int p, f;
    logic [31:0] codes;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      codes = (i < FRAME_LEN) ? {8'h81, 8'hCF, 8'h92, 8'h86} : {8'h81, 8'hA4, 8'h92, 8'h86};
      step(p, f);
      total++; if (an !== exp_an(p, f)) begin bad++; $display("FAIL snap_an f%0d p%0d: got %h want %h", f, p, an, exp_an(p, f)); end
      total++; if (seg !== exp_seg(p, f, codes)) begin bad++; $display("FAIL snap_seg f%0d p%0d: got %h want %h", f, p, seg, exp_seg(p, f, codes)); end
      total++; if (frame !== (p == FRAME_LEN - 1)) begin bad++; $display("FAIL snap_frame f%0d p%0d: got %b", f, p, frame); end
      if (i == 12) d2 = 8'hA4;
      if (i == FRAME_LEN + 30) d3 = 8'hB0;
      if (i == FRAME_LEN + 31) d1 = 8'hF9;
    end
  endtask

  task automatic test_frame_capture();
    int p, f;
    logic [31:0] codes;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      codes = (i < FRAME_LEN) ? {8'h81, 8'hA4, 8'hB0, 8'h86} : {8'hF9, 8'hA4, 8'hB0, 8'h86};
      step(p, f);
      total++; if (an !== exp_an(p, f)) begin bad++; $display("FAIL cap_an f%0d p%0d: got %h want %h", f, p, an, exp_an(p, f)); end
      total++; if (seg !== exp_seg(p, f, codes)) begin bad++; $display("FAIL cap_seg f%0d p%0d: got %h want %h", f, p, seg, exp_seg(p, f, codes)); end
      total++; if (frame !== (p == FRAME_LEN - 1)) begin bad++; $display("FAIL cap_frame f%0d p%0d: got %b", f, p, frame); end
    end
  endtask

  task automatic test_async_reset();
    int p, f;
    logic [31:0] codes = {8'hF9, 8'hA4, 8'hB0, 8'h86};
    int guard = 0;
    p = -1;
    while (p != 20 && guard < 2 * FRAME_LEN) begin
      step(p, f);
      guard++;
    end
    total++; if (p != 20) begin bad++; $display("FAIL async_reach: got p%0d want p20", p); end
    total++; if (seg !== 8'hB0) begin bad++; $display("FAIL async_pre_seg: got %h want b0", seg); end
    #2 rst = 1'b1;
    #1;
    total++; if (seg !== 8'hFF) begin bad++; $display("FAIL async_seg: got %h want ff", seg); end
    total++; if (an !== 4'hF) begin bad++; $display("FAIL async_an: got %h want f", an); end
    total++; if (frame !== 1'b0) begin bad++; $display("FAIL async_frame: got %b want 0", frame); end
    @(negedge clknew);
    rst = 1'b0;
    ec  = 0;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      step(p, f);
      total++; if (an !== exp_an(p, f)) begin bad++; $display("FAIL rst_an f%0d p%0d: got %h want %h", f, p, an, exp_an(p, f)); end
      total++; if (seg !== exp_seg(p, f, codes)) begin bad++; $display("FAIL rst_seg f%0d p%0d: got %h want %h", f, p, seg, exp_seg(p, f, codes)); end
      total++; if (frame !== (p == FRAME_LEN - 1)) begin bad++; $display("FAIL rst_frame f%0d p%0d: got %b", f, p, frame); end
    end
  endtask

  task automatic test_markers();
    int p, f;
    logic [7:0] marks [2] = '{8'h01, 8'hFE};
    logic [31:0] codes;
    for (int m = 0; m < 2; m++) begin
      d4 = marks[m];
      codes = {8'hF9, 8'hA4, 8'hB0, marks[m]};
      do_reset();
      for (int i = 0; i < 2 * FRAME_LEN; i++) begin
        step(p, f);
        total++; if (an !== exp_an(p, f)) begin bad++; $display("FAIL mark_an m%0d f%0d p%0d: got %h want %h", m, f, p, an, exp_an(p, f)); end
        total++; if (seg !== exp_seg(p, f, codes)) begin bad++; $display("FAIL mark_seg m%0d f%0d p%0d: got %h want %h", m, f, p, seg, exp_seg(p, f, codes)); end
      end
    end
  endtask

`ifdef CURSOR_BLINK_EN
  task automatic test_blink();
    int p, f;
    logic [31:0] codes = {8'hF9, 8'hA4, 8'hB0, 8'h86};
    d4 = 8'h86;
    do_reset();
    for (int i = 0; i < 6 * FRAME_LEN; i++) begin
      step(p, f);
      total++; if (an !== exp_an(p, f)) begin bad++; $display("FAIL blink_an f%0d p%0d: got %h want %h", f, p, an, exp_an(p, f)); end
      total++; if (seg !== exp_seg(p, f, codes)) begin bad++; $display("FAIL blink_seg f%0d p%0d: got %h want %h", f, p, seg, exp_seg(p, f, codes)); end
    end
  endtask
`endif

  initial begin
    d1 = 8'h81;
    d2 = 8'hCF;
    d3 = 8'h92;
    d4 = 8'h86;
    test_reset();
    test_display();
    test_snapshot();
    test_frame_capture();
    test_async_reset();
    test_markers();
`ifdef CURSOR_BLINK_EN
    test_blink();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
